// File: rtl/ibex_rf_wr_arbiter_pkg.sv
// rtl/ibex_rf_wr_arbiter_pkg.sv - shared types for the register-file write arbiter
// Purpose: write-source encoding, write-request payload, CAM address-compare helper.
package ibex_rf_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    RF_WR_NONE = 2'd0,
    RF_WR_ID   = 2'd1,
    RF_WR_LSU  = 2'd2,
    RF_WR_CP   = 2'd3
  } rf_wr_src_e;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wr_req_t;

  // x0 is never a hazard: reads of x0 always return zero regardless of pending writes.
  function automatic logic addr_hit(input logic [4:0] entry_addr, input logic [4:0] raddr);
    return (raddr != 5'd0) && (entry_addr == raddr);
  endfunction

endpackage

// File: rtl/ibex_rf_wr_fifo.sv
// rtl/ibex_rf_wr_fifo.sv - circular load write-buffer with dual CAM read-address compare
// Purpose: holds load responses until the RF write port is free.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   push_i, push_data_i     enqueue request (dropped only if full with no pop)
//   pop_i                   dequeue head (ignored when empty)
//   head_o                  oldest entry
//   full_o, empty_o         occupancy flags
//   raddr_a_i/raddr_b_i     operand addresses to compare against buffered entries
//   hit_a_o/hit_b_o         some valid entry targets the given (non-zero) address
module ibex_rf_wr_fifo
  import ibex_rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  rf_wr_req_t push_data_i,
  input  logic       pop_i,
  output rf_wr_req_t head_o,
  output logic       full_o,
  output logic       empty_o,
  input  logic [4:0] raddr_a_i,
  input  logic [4:0] raddr_b_i,
  output logic       hit_a_o,
  output logic       hit_b_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  rf_wr_req_t            mem_q [Depth];
  logic [Depth-1:0]      valid_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // Per-entry valid bits make full/empty and the CAM qualification trivial.
  assign full_o  = &valid_q;
  assign empty_o = ~|valid_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      // Placed after the pop so a full push+pop on the same slot leaves it valid.
      if (do_push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    hit_a_o = 1'b0;
    hit_b_o = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (valid_q[i] && addr_hit(mem_q[i].waddr, raddr_a_i)) hit_a_o = 1'b1;
      if (valid_q[i] && addr_hit(mem_q[i].waddr, raddr_b_i)) hit_b_o = 1'b1;
    end
  end

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// rtl/ibex_rf_wr_arbiter.sv - register-file write-port arbiter for ID, LSU and coprocessor
// Purpose: grants the single RF write port to one producer per cycle, buffers
//   non-stallable load data, prevents coprocessor starvation, and flags RAW hazards.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   id_we_i/id_waddr_i/id_wdata_i        ID write request; id_ready_o = accepted
//   lsu_we_i/lsu_waddr_i/lsu_wdata_i     load response, always enqueued
//   cp_valid_i/cp_waddr_i/cp_wdata_i     coprocessor request; cp_ready_o = grant
//   raddr_a_i/raddr_b_i, hazard_a/b_o    buffered-load RAW hazard flags
//   rf_we_o/rf_waddr_o/rf_wdata_o        RF write port
//   rf_wr_src_o                          granted source (rf_wr_src_e)
//   lsu_overflow_o                       sticky load-buffer overflow checker
module ibex_rf_wr_arbiter
  import ibex_rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned LsuBufDepth = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_we_i,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_wdata_i,
  output logic        id_ready_o,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        cp_valid_i,
  input  logic [4:0]  cp_waddr_i,
  input  logic [31:0] cp_wdata_i,
  output logic        cp_ready_o,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic        hazard_a_o,
  output logic        hazard_b_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [1:0]  rf_wr_src_o,
  output logic        lsu_overflow_o
);

  localparam int unsigned CntW = $clog2(StarveLimit + 1);

  rf_wr_src_e      grant;
  rf_wr_req_t      fifo_head;
  rf_wr_req_t      lsu_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_hit_a;
  logic            fifo_hit_b;
  logic [CntW-1:0] starve_cnt_q;
  logic [CntW-1:0] starve_cnt_d;
  logic            starve;

  assign lsu_req = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};

  ibex_rf_wr_fifo #(
    .Depth(LsuBufDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (lsu_we_i),
    .push_data_i(lsu_req),
    .pop_i      (grant == RF_WR_LSU),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .raddr_a_i  (raddr_a_i),
    .raddr_b_i  (raddr_b_i),
    .hit_a_o    (fifo_hit_a),
    .hit_b_o    (fifo_hit_b)
  );

  assign starve = (starve_cnt_q == CntW'(StarveLimit));

  // A full buffer must drain first: the LSU cannot be stalled, so the next
  // load would otherwise have nowhere to go.
  always_comb begin
    grant = RF_WR_NONE;
    if (rst_i) begin
      grant = RF_WR_NONE;
    end else if (fifo_full) begin
      grant = RF_WR_LSU;
    end else if (starve && cp_valid_i) begin
      grant = RF_WR_CP;
    end else if (id_we_i) begin
      grant = RF_WR_ID;
    end else if (!fifo_empty) begin
      grant = RF_WR_LSU;
    end else if (cp_valid_i) begin
      grant = RF_WR_CP;
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    unique case (grant)
      RF_WR_ID: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = id_waddr_i;
        rf_wdata_o = id_wdata_i;
      end
      RF_WR_LSU: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = fifo_head.waddr;
        rf_wdata_o = fifo_head.wdata;
      end
      RF_WR_CP: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = cp_waddr_i;
        rf_wdata_o = cp_wdata_i;
      end
      default: ;
    endcase
  end

  assign rf_wr_src_o = grant;
  // Deliberately independent of id_we_i so ID can use it as a stall condition.
  assign id_ready_o  = ~rst_i & ~fifo_full & ~(starve & cp_valid_i);
  assign cp_ready_o  = (grant == RF_WR_CP);
  assign hazard_a_o  = ~rst_i & fifo_hit_a;
  assign hazard_b_o  = ~rst_i & fifo_hit_b;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cp_valid_i || cp_ready_o) begin
      starve_cnt_d = '0;
    end else if (!starve) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q   <= '0;
      lsu_overflow_o <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if (lsu_we_i && fifo_full && (grant != RF_WR_LSU)) begin
        lsu_overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// tb/tb_ibex_rf_wr_arbiter.sv - self-checking bench for ibex_rf_wr_arbiter
module tb_ibex_rf_wr_arbiter;
  import ibex_rf_wr_arbiter_pkg::*;

  localparam int Depth = 2;
  localparam int Limit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_we, lsu_we, cp_valid;
  logic [4:0]  id_waddr, lsu_waddr, cp_waddr, raddr_a, raddr_b;
  logic [31:0] id_wdata, lsu_wdata, cp_wdata;
  logic        id_ready, cp_ready, haz_a, haz_b, rf_we, ovf;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  rf_src;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // {rf_we, rf_waddr, rf_wdata, src, id_ready, cp_ready}
  wire [41:0] obs = {rf_we, rf_waddr, rf_wdata, rf_src, id_ready, cp_ready};

  ibex_rf_wr_arbiter #(.LsuBufDepth(Depth), .StarveLimit(Limit)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_we_i(id_we), .id_waddr_i(id_waddr), .id_wdata_i(id_wdata), .id_ready_o(id_ready),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .cp_valid_i(cp_valid), .cp_waddr_i(cp_waddr), .cp_wdata_i(cp_wdata), .cp_ready_o(cp_ready),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_a_o(haz_a), .hazard_b_o(haz_b),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_wr_src_o(rf_src),
    .lsu_overflow_o(ovf)
  );

  task automatic idle_inputs();
    id_we = 0; id_waddr = 0; id_wdata = 0;
    lsu_we = 0; lsu_waddr = 0; lsu_wdata = 0;
    cp_valid = 0; cp_waddr = 0; cp_wdata = 0;
    raddr_a = 0; raddr_b = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic set_id(input logic we, input logic [4:0] a, input logic [31:0] d);
    id_we = we; id_waddr = a; id_wdata = d;
  endtask

  task automatic set_lsu(input logic we, input logic [4:0] a, input logic [31:0] d);
    lsu_we = we; lsu_waddr = a; lsu_wdata = d;
  endtask

  task automatic test_reset();
    logic [41:0] exp;
    idle_inputs();
    rst = 1;
    set_id(1, 5'd4, 32'h44); set_lsu(1, 5'd6, 32'h66);
    cp_valid = 1; cp_waddr = 5'd7; raddr_a = 5'd6; raddr_b = 5'd6;
    @(posedge clk);
    @(negedge clk);
    exp = {1'b0, 5'd0, 32'd0, RF_WR_NONE, 1'b0, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_outputs got %h want %h", obs, exp); end
    n_vec++;
    if ({haz_a, haz_b, ovf} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {haz_a, haz_b, ovf});
    end
    next_cycle();
    apply_reset();
  endtask

  task automatic test_id_only();
    logic [41:0] exp;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'd5, 32'h11);
      @(negedge clk);
      exp = {1'b1, 5'd5, 32'h11, RF_WR_ID, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp) begin n_fail++; $display("FAIL id_only[%0d] got %h want %h", i, obs, exp); end
      next_cycle();
    end
    idle_inputs();
    id_waddr = 5'd9; id_wdata = 32'hdead;
    @(negedge clk);
    exp = {1'b0, 5'd0, 32'd0, RF_WR_NONE, 1'b1, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_fail++; $display("FAIL id_idle_zero got %h want %h", obs, exp); end
    next_cycle();
  endtask

  task automatic test_load_queuing();
    logic [41:0] exp [5];
    exp[0] = {1'b1, 5'd3, 32'h33, RF_WR_ID,  1'b1, 1'b0};
    exp[1] = {1'b1, 5'd3, 32'h33, RF_WR_ID,  1'b1, 1'b0};
    exp[2] = {1'b1, 5'd7, 32'hAA, RF_WR_LSU, 1'b0, 1'b0};
    exp[3] = {1'b1, 5'd3, 32'h33, RF_WR_ID,  1'b1, 1'b0};
    exp[4] = {1'b1, 5'd8, 32'hBB, RF_WR_LSU, 1'b1, 1'b0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_id(c < 4, 5'd3, 32'h33);
      if (c == 0) set_lsu(1, 5'd7, 32'hAA);
      else if (c == 1) set_lsu(1, 5'd8, 32'hBB);
      else set_lsu(0, 5'd0, 32'd0);
      @(negedge clk);
      n_vec++;
      if (obs !== exp[c]) begin n_fail++; $display("FAIL load_queue[%0d] got %h want %h", c, obs, exp[c]); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_hazard();
    apply_reset();
    set_id(1, 5'd1, 32'h1); set_lsu(1, 5'd9, 32'h99);
    next_cycle();
    set_lsu(0, 5'd0, 32'd0); raddr_a = 5'd9; raddr_b = 5'd0;
    @(negedge clk);
    n_vec++;
    if ({haz_a, haz_b} !== 2'b10) begin n_fail++; $display("FAIL hazard_held got %b want 10", {haz_a, haz_b}); end
    next_cycle();
    set_id(0, 5'd0, 32'd0);
    @(negedge clk);
    n_vec++;
    if ({haz_a, rf_src, rf_waddr} !== {1'b1, RF_WR_LSU, 5'd9}) begin
      n_fail++; $display("FAIL hazard_pop got %b/%0d/%0d want 1/2/9", haz_a, rf_src, rf_waddr);
    end
    next_cycle();
    set_lsu(1, 5'd9, 32'h5);
    @(negedge clk);
    n_vec++;
    if (haz_a !== 1'b0) begin n_fail++; $display("FAIL hazard_after_pop got %b want 0", haz_a); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_starvation();
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      cp_valid = 1; cp_waddr = 5'd12 + 5'(round); cp_wdata = 32'hCC + round;
      for (int c = 0; c < 5; c++) begin
        set_id(1, 5'd3, 32'h33);
        @(negedge clk);
        n_vec++;
        if (c < 4) begin
          if ({cp_ready, rf_src} !== {1'b0, RF_WR_ID}) begin
            n_fail++; $display("FAIL starve_wait[%0d.%0d] got %b/%0d want 0/1", round, c, cp_ready, rf_src);
          end
        end else if (obs !== {1'b1, cp_waddr, cp_wdata, RF_WR_CP, 1'b0, 1'b1}) begin
          n_fail++; $display("FAIL starve_grant[%0d] got %h want %h", round, obs,
                             {1'b1, cp_waddr, cp_wdata, RF_WR_CP, 1'b0, 1'b1});
        end
        next_cycle();
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_push_pop();
    logic [41:0] exp [5];
    exp[0] = {1'b1, 5'd1,  32'h1, RF_WR_ID,  1'b1, 1'b0};
    exp[1] = {1'b1, 5'd1,  32'h1, RF_WR_ID,  1'b1, 1'b0};
    exp[2] = {1'b1, 5'd20, 32'h1, RF_WR_LSU, 1'b0, 1'b0};
    exp[3] = {1'b1, 5'd21, 32'h2, RF_WR_LSU, 1'b0, 1'b0};
    exp[4] = {1'b1, 5'd22, 32'h3, RF_WR_LSU, 1'b1, 1'b0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      set_id(c < 2, 5'd1, 32'h1);
      set_lsu(c < 3, 5'd20 + 5'(c), 32'(c + 1));
      @(negedge clk);
      n_vec++;
      if (obs !== exp[c]) begin n_fail++; $display("FAIL full_pushpop[%0d] got %h want %h", c, obs, exp[c]); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_overflow got %b want 0", ovf); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cp_valid = 1; cp_waddr = 5'd12; cp_wdata = 32'hCC;
    for (int c = 0; c < 3; c++) begin
      set_id(1, 5'd3, 32'h33);
      set_lsu(1, 5'd5 + 5'(c), 32'h55 + c);
      next_cycle();
    end
    rst = 1; raddr_a = 5'd6; raddr_b = 5'd7;
    @(negedge clk);
    n_vec++;
    if ({rf_we, cp_ready, id_ready, haz_a, haz_b} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_outputs got %b want 00000", {rf_we, cp_ready, id_ready, haz_a, haz_b});
    end
    next_cycle();
    rst = 0; set_lsu(0, 5'd0, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (c == 0 && {haz_a, haz_b, rf_src} !== {2'b00, RF_WR_ID}) begin
        n_fail++; $display("FAIL midreset_empty got %b/%0d want 00/1", {haz_a, haz_b}, rf_src);
      end else if (c > 0 && cp_ready !== (c == 4)) begin
        n_fail++; $display("FAIL midreset_counter[%0d] got %b want %b", c, cp_ready, c == 4);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    rf_wr_req_t  q[$];
    int          cnt;
    bit          cp_done;
    bit          mod_ovf;
    logic [1:0]  esrc;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [41:0] exp;
    logic        eha, ehb;
    apply_reset();
    cnt = 0; cp_done = 0; mod_ovf = 0;
    for (int n = 0; n < 600; n++) begin
      if (cp_done) cp_valid = 0;
      cp_done = 0;
      rst = ($urandom_range(0, 99) == 0);
      set_id($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      set_lsu($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom);
      if (!cp_valid && $urandom_range(0, 3) == 0) begin
        cp_valid = 1; cp_waddr = 5'($urandom_range(0, 7)); cp_wdata = $urandom;
      end
      raddr_a = 5'($urandom_range(0, 7)); raddr_b = 5'($urandom_range(0, 7));
      @(negedge clk);
      esrc = RF_WR_NONE; ea = 0; ed = 0; eha = 0; ehb = 0;
      if (!rst) begin
        if (q.size() == Depth) esrc = RF_WR_LSU;
        else if (cnt == Limit && cp_valid) esrc = RF_WR_CP;
        else if (id_we) esrc = RF_WR_ID;
        else if (q.size() > 0) esrc = RF_WR_LSU;
        else if (cp_valid) esrc = RF_WR_CP;
        if (esrc == RF_WR_ID) begin ea = id_waddr; ed = id_wdata; end
        if (esrc == RF_WR_LSU) begin ea = q[0].waddr; ed = q[0].wdata; end
        if (esrc == RF_WR_CP) begin ea = cp_waddr; ed = cp_wdata; end
        foreach (q[i]) begin
          if (raddr_a != 0 && q[i].waddr == raddr_a) eha = 1;
          if (raddr_b != 0 && q[i].waddr == raddr_b) ehb = 1;
        end
      end
      exp = {esrc != RF_WR_NONE, ea, ed, esrc,
             !rst && q.size() != Depth && !(cnt == Limit && cp_valid), esrc == RF_WR_CP};
      n_vec++;
      if ({obs, haz_a, haz_b, ovf} !== {exp, eha, ehb, mod_ovf}) begin
        n_fail++;
        $display("FAIL random[%0d] got %h/%b%b%b want %h/%b%b%b", n, obs, haz_a, haz_b, ovf,
                 exp, eha, ehb, mod_ovf);
      end
      if (rst) begin
        q.delete(); cnt = 0; mod_ovf = 0;
      end else begin
        if (esrc == RF_WR_LSU) void'(q.pop_front());
        if (lsu_we) begin
          if (q.size() < Depth) q.push_back('{waddr: lsu_waddr, wdata: lsu_wdata});
          else mod_ovf = 1;
        end
        if (!cp_valid || esrc == RF_WR_CP) cnt = 0;
        else if (cnt < Limit) cnt++;
        cp_done = (esrc == RF_WR_CP);
      end
      next_cycle();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_id_only();
    test_load_queuing();
    test_hazard();
    test_starvation();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
